// File: rtl/cr16_pkg.sv
// Shared encodings, field positions and helpers for the CR16 control path.
package cr16_pkg;

   // Instruction field positions
   localparam int OP_MSB    = 15;
   localparam int OP_LSB    = 12;
   localparam int RDEST_MSB = 11;
   localparam int RDEST_LSB = 8;
   localparam int EXT_MSB   = 7;
   localparam int EXT_LSB   = 4;
   localparam int RSRC_MSB  = 3;
   localparam int RSRC_LSB  = 0;
   localparam int IMM_MSB   = 7;
   localparam int IMM_LSB   = 0;

   // Major opcodes; immediate ALU forms reuse the ALU opcode value
   localparam logic [3:0] OP_RR    = 4'b0000;
   localparam logic [3:0] OP_ANDI  = 4'b0001;
   localparam logic [3:0] OP_ORI   = 4'b0010;
   localparam logic [3:0] OP_XORI  = 4'b0011;
   localparam logic [3:0] OP_MEM   = 4'b0100;
   localparam logic [3:0] OP_ADDI  = 4'b0101;
   localparam logic [3:0] OP_SUBI  = 4'b1001;
   localparam logic [3:0] OP_CMPI  = 4'b1011;
   localparam logic [3:0] OP_BCOND = 4'b1100;
   localparam logic [3:0] OP_MOVI  = 4'b1101;
   localparam logic [3:0] OP_LUI   = 4'b1111;

   // Extension codes under OP_MEM
   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JCOND = 4'b1100;

   // ALU opcodes as understood by the datapath
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_ADD = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b1001;
   localparam logic [3:0] ALU_CMP = 4'b1011;
   localparam logic [3:0] ALU_MOV = 4'b1101;

   // Condition codes
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_HI = 4'b0100;
   localparam logic [3:0] COND_LS = 4'b0101;
   localparam logic [3:0] COND_GT = 4'b0110;
   localparam logic [3:0] COND_LE = 4'b0111;
   localparam logic [3:0] COND_FS = 4'b1000;
   localparam logic [3:0] COND_FC = 4'b1001;
   localparam logic [3:0] COND_LO = 4'b1010;
   localparam logic [3:0] COND_HS = 4'b1011;
   localparam logic [3:0] COND_LT = 4'b1100;
   localparam logic [3:0] COND_GE = 4'b1101;
   localparam logic [3:0] COND_UC = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Bit positions inside the 5-bit status flag vector
   localparam int FLAG_C = 0;
   localparam int FLAG_L = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 4;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_LOAD_WB,
      ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LOAD,
      CLS_STOR,
      CLS_JCOND,
      CLS_BCOND,
      CLS_ILLEGAL
   } cls_e;

   function automatic logic alu_code_valid(input logic [3:0] code);
      return (code == ALU_AND) || (code == ALU_OR)  || (code == ALU_XOR) ||
             (code == ALU_ADD) || (code == ALU_SUB) || (code == ALU_CMP) ||
             (code == ALU_MOV);
   endfunction

   function automatic logic cond_met(input logic [3:0] cond, input logic [4:0] flags);
      logic c, l, f, z, n;
      c = flags[FLAG_C];
      l = flags[FLAG_L];
      f = flags[FLAG_F];
      z = flags[FLAG_Z];
      n = flags[FLAG_N];
      case (cond)
         COND_EQ: return z;
         COND_NE: return !z;
         COND_CS: return c;
         COND_CC: return !c;
         COND_HI: return l;
         COND_LS: return !l;
         COND_GT: return n;
         COND_LE: return !n;
         COND_FS: return f;
         COND_FC: return !f;
         COND_LO: return !l && !z;
         COND_HS: return l || z;
         COND_LT: return !n && !z;
         COND_GE: return n || z;
         COND_UC: return 1'b1;
         COND_NV: return 1'b0;
         default: return 1'b0;
      endcase
   endfunction

   // Arithmetic immediates and branch displacements are signed; logic/move are not
   function automatic logic [15:0] imm_extend(input logic [3:0] op, input logic [7:0] imm8);
      case (op)
         OP_ADDI, OP_SUBI, OP_CMPI, OP_BCOND: return {{8{imm8[7]}}, imm8};
         OP_LUI:                              return {imm8, 8'h00};
         default:                             return {8'h00, imm8};
      endcase
   endfunction

endpackage

// File: rtl/cr16_decoder.sv
// Combinational instruction classifier: class, ALU opcode, immediate and write/flag hints.
module cr16_decoder
   import cr16_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [3:0]  i_ext,
   input  logic [7:0]  i_imm8,
   output cls_e        o_cls,
   output logic [3:0]  o_alu_op,
   output logic [15:0] o_immediate,
   output logic        o_imm_select,
   output logic        o_writes_reg,
   output logic        o_sets_flags,
   output logic        o_illegal
);

   logic [3:0] alu_code;

   // Classify the instruction word and derive the datapath controls it needs
   always_comb begin
      o_cls        = CLS_ILLEGAL;
      o_alu_op     = ALU_MOV;
      o_immediate  = imm_extend(i_op, i_imm8);
      o_imm_select = 1'b0;
      o_writes_reg = 1'b0;
      o_sets_flags = 1'b0;
      alu_code     = (i_op == OP_RR) ? i_ext : i_op;
      case (i_op)
         OP_RR, OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: begin
            if (alu_code_valid(alu_code)) begin
               o_cls        = CLS_ALU;
               o_alu_op     = alu_code;
               o_imm_select = (i_op != OP_RR);
               o_writes_reg = (alu_code != ALU_CMP);
               o_sets_flags = (alu_code == ALU_ADD) || (alu_code == ALU_SUB) ||
                              (alu_code == ALU_CMP);
            end
         end
         OP_LUI: begin
            o_cls        = CLS_ALU;
            o_alu_op     = ALU_MOV;
            o_imm_select = 1'b1;
            o_writes_reg = 1'b1;
         end
         OP_MEM: begin
            case (i_ext)
               EXT_LOAD: begin
                  o_cls        = CLS_LOAD;
                  o_writes_reg = 1'b1;
               end
               EXT_STOR:  o_cls = CLS_STOR;
               EXT_JCOND: o_cls = CLS_JCOND;
               default:   o_cls = CLS_ILLEGAL;
            endcase
         end
         OP_BCOND: o_cls = CLS_BCOND;
         default:  o_cls = CLS_ILLEGAL;
      endcase
      o_illegal = (o_cls == CLS_ILLEGAL);
   end

endmodule

// File: rtl/cr16_controller.sv
// Multi-cycle fetch/decode/execute controller driving the CR16 datapath and memory port.
module cr16_controller
   import cr16_pkg::*;
#(
   parameter logic [15:0] P_PC_RESET = 16'h0000
) (
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic        I_ENABLE,
   input  logic [15:0] I_A,
   input  logic [15:0] I_B,
   input  logic [4:0]  I_STATUS_FLAGS,
   input  logic [15:0] I_MEM_RDATA,
   output logic [15:0] O_MEM_ADDR,
   output logic        O_MEM_WE,
   output logic [15:0] O_MEM_WDATA,
   output logic        O_DP_ENABLE,
   output logic [15:0] O_REG_WRITE_ENABLE,
   output logic [3:0]  O_REG_A_SELECT,
   output logic [3:0]  O_REG_B_SELECT,
   output logic        O_IMMEDIATE_SELECT,
   output logic [15:0] O_IMMEDIATE,
   output logic [3:0]  O_OPCODE,
   output logic        O_REG_DATA_SELECT,
   output logic [15:0] O_PC,
   output logic        O_HALTED
);

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [4:0]  flags_q, flags_d;
   logic        flag_pending_q, flag_pending_d;

   logic [15:0] dec_instr;
   cls_e        dec_cls;
   logic [3:0]  dec_alu_op;
   logic [15:0] dec_immediate;
   logic        dec_imm_select;
   logic        dec_writes_reg;
   logic        dec_sets_flags;
   logic        dec_illegal;

   logic [3:0]  rdest;
   logic [3:0]  rsrc;
   logic [15:0] pc_inc;
   logic [15:0] br_target;
   logic        taken;

   // In DECODE the incoming word is classified so an illegal op never reaches EXECUTE
   assign dec_instr = (state_q == ST_DECODE) ? I_MEM_RDATA : ir_q;

   cr16_decoder u_decoder (
      .i_op         (dec_instr[OP_MSB:OP_LSB]),
      .i_ext        (dec_instr[EXT_MSB:EXT_LSB]),
      .i_imm8       (dec_instr[IMM_MSB:IMM_LSB]),
      .o_cls        (dec_cls),
      .o_alu_op     (dec_alu_op),
      .o_immediate  (dec_immediate),
      .o_imm_select (dec_imm_select),
      .o_writes_reg (dec_writes_reg),
      .o_sets_flags (dec_sets_flags),
      .o_illegal    (dec_illegal)
   );

   assign rdest     = ir_q[RDEST_MSB:RDEST_LSB];
   assign rsrc      = ir_q[RSRC_MSB:RSRC_LSB];
   assign pc_inc    = pc_q + 16'd1;
   assign br_target = pc_q + dec_immediate;
   assign taken     = cond_met(rdest, flags_q);

   // Next-state, PC, IR and flag snapshot; everything holds while I_ENABLE is low
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      ir_d           = ir_q;
      flags_d        = flags_q;
      flag_pending_d = flag_pending_q;
      if (I_ENABLE) begin
         case (state_q)
            ST_FETCH: begin
               if (flag_pending_q) begin
                  flags_d        = I_STATUS_FLAGS;
                  flag_pending_d = 1'b0;
               end
               state_d = ST_DECODE;
            end
            ST_DECODE: begin
               ir_d    = I_MEM_RDATA;
               state_d = dec_illegal ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
               state_d = ST_FETCH;
               case (dec_cls)
                  CLS_ALU: begin
                     pc_d = pc_inc;
                     if (dec_sets_flags) flag_pending_d = 1'b1;
                  end
                  CLS_LOAD:  state_d = ST_LOAD_WB;
                  CLS_STOR:  pc_d = pc_inc;
                  CLS_JCOND: pc_d = taken ? I_A : pc_inc;
                  CLS_BCOND: pc_d = taken ? br_target : pc_inc;
                  default:   state_d = ST_HALT;
               endcase
            end
            ST_LOAD_WB: begin
               pc_d    = pc_inc;
               state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
         endcase
      end
   end

   // Control state registers with synchronous reset
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_q        <= ST_FETCH;
         pc_q           <= P_PC_RESET;
         ir_q           <= '0;
         flags_q        <= '0;
         flag_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         ir_q           <= ir_d;
         flags_q        <= flags_d;
         flag_pending_q <= flag_pending_d;
      end
   end

   // Datapath and memory controls decoded from the current state and IR
   always_comb begin
      O_MEM_ADDR         = pc_q;
      O_MEM_WE           = 1'b0;
      O_DP_ENABLE        = 1'b0;
      O_REG_WRITE_ENABLE = '0;
      O_REG_DATA_SELECT  = 1'b0;
      O_HALTED           = 1'b0;
      case (state_q)
         ST_EXECUTE: begin
            case (dec_cls)
               CLS_ALU: begin
                  O_DP_ENABLE = 1'b1;
                  if (dec_writes_reg) O_REG_WRITE_ENABLE = 16'h0001 << rdest;
               end
               CLS_LOAD: O_MEM_ADDR = I_A;
               CLS_STOR: begin
                  O_MEM_ADDR = I_A;
                  O_MEM_WE   = 1'b1;
               end
               default: O_MEM_ADDR = pc_q;
            endcase
         end
         ST_LOAD_WB: begin
            O_DP_ENABLE        = 1'b1;
            O_REG_DATA_SELECT  = 1'b1;
            O_REG_WRITE_ENABLE = 16'h0001 << rdest;
         end
         ST_HALT: O_HALTED = 1'b1;
         default: O_MEM_ADDR = pc_q;
      endcase
      if (!I_ENABLE || I_RESET) begin
         O_DP_ENABLE = 1'b0;
         O_MEM_WE    = 1'b0;
      end
      if (I_RESET) O_REG_WRITE_ENABLE = '0;
   end

   assign O_MEM_WDATA        = I_B;
   assign O_REG_A_SELECT     = rsrc;
   assign O_REG_B_SELECT     = rdest;
   assign O_IMMEDIATE_SELECT = dec_imm_select;
   assign O_IMMEDIATE        = dec_immediate;
   assign O_OPCODE           = dec_alu_op;
   assign O_PC               = pc_q;

endmodule

// File: tb/tb_cr16_controller.sv
// Directed bench for cr16_controller with a synchronous-read memory model.
module tb_cr16_controller;

   logic        I_CLK = 1'b0;
   logic        I_RESET;
   logic        I_ENABLE;
   logic [15:0] I_A;
   logic [15:0] I_B;
   logic [4:0]  I_STATUS_FLAGS;
   logic [15:0] I_MEM_RDATA = 16'h0000;
   logic [15:0] O_MEM_ADDR;
   logic        O_MEM_WE;
   logic [15:0] O_MEM_WDATA;
   logic        O_DP_ENABLE;
   logic [15:0] O_REG_WRITE_ENABLE;
   logic [3:0]  O_REG_A_SELECT;
   logic [3:0]  O_REG_B_SELECT;
   logic        O_IMMEDIATE_SELECT;
   logic [15:0] O_IMMEDIATE;
   logic [3:0]  O_OPCODE;
   logic        O_REG_DATA_SELECT;
   logic [15:0] O_PC;
   logic        O_HALTED;

   logic [15:0] mem [0:65535];

   int total = 0;
   int bad   = 0;

   cr16_controller #(.P_PC_RESET(16'h0010)) dut (
      .I_CLK              (I_CLK),
      .I_RESET            (I_RESET),
      .I_ENABLE           (I_ENABLE),
      .I_A                (I_A),
      .I_B                (I_B),
      .I_STATUS_FLAGS     (I_STATUS_FLAGS),
      .I_MEM_RDATA        (I_MEM_RDATA),
      .O_MEM_ADDR         (O_MEM_ADDR),
      .O_MEM_WE           (O_MEM_WE),
      .O_MEM_WDATA        (O_MEM_WDATA),
      .O_DP_ENABLE        (O_DP_ENABLE),
      .O_REG_WRITE_ENABLE (O_REG_WRITE_ENABLE),
      .O_REG_A_SELECT     (O_REG_A_SELECT),
      .O_REG_B_SELECT     (O_REG_B_SELECT),
      .O_IMMEDIATE_SELECT (O_IMMEDIATE_SELECT),
      .O_IMMEDIATE        (O_IMMEDIATE),
      .O_OPCODE           (O_OPCODE),
      .O_REG_DATA_SELECT  (O_REG_DATA_SELECT),
      .O_PC               (O_PC),
      .O_HALTED           (O_HALTED)
   );

   always #5 I_CLK = ~I_CLK;

   // Read data appears one clock after the address
   always @(posedge I_CLK) I_MEM_RDATA <= mem[O_MEM_ADDR];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge I_CLK);
      #1;
   endtask

   initial begin
      I_RESET        = 1'b1;
      I_ENABLE       = 1'b1;
      I_A            = 16'h0000;
      I_B            = 16'h0000;
      I_STATUS_FLAGS = 5'b00000;
      mem[16'h0010]  = 16'hD37F;   // MOVI R3,#0x7F
      mem[16'h0011]  = 16'h51FF;   // ADDI R1,#-1
      mem[16'h0012]  = 16'h01B2;   // CMP  R2,R1
      mem[16'h0013]  = 16'hC1FE;   // BNE  -2
      mem[16'h0014]  = 16'hC0FE;   // BEQ  -2
      mem[16'hFFFF]  = 16'hCE01;   // BUC  +1
      mem[16'h0000]  = 16'h4405;   // LOAD R4,[R5]
      mem[16'h0200]  = 16'hBEEF;
      mem[16'h0001]  = 16'h4647;   // STOR R6,[R7]
      mem[16'h0002]  = 16'h6000;   // illegal

      tick();
      tick();
      chk("rst_pc",      32'(O_PC), 32'h0010);
      chk("rst_addr",    32'(O_MEM_ADDR), 32'h0010);
      chk("rst_halted",  32'(O_HALTED), 32'h0);
      chk("rst_enables", 32'({O_DP_ENABLE, O_MEM_WE, O_REG_WRITE_ENABLE}), 32'h0);
      I_RESET = 1'b0;

      // MOVI R3,#0x7F
      tick();
      tick();
      chk("movi_we",     32'(O_REG_WRITE_ENABLE), 32'h0008);
      chk("movi_imm",    32'(O_IMMEDIATE), 32'h007F);
      chk("movi_immsel", 32'(O_IMMEDIATE_SELECT), 32'h1);
      chk("movi_op",     32'(O_OPCODE), 32'hD);
      chk("movi_dpen",   32'(O_DP_ENABLE), 32'h1);
      tick();
      chk("movi_pc",     32'(O_PC), 32'h0011);
      chk("fetch_addr",  32'(O_MEM_ADDR), 32'h0011);

      // ADDI R1,#-1
      tick();
      tick();
      chk("addi_imm", 32'(O_IMMEDIATE), 32'hFFFF);
      chk("addi_we",  32'(O_REG_WRITE_ENABLE), 32'h0002);
      chk("addi_op",  32'(O_OPCODE), 32'h5);

      // CMP R2,R1: no register write; datapath then reports Z
      tick();
      tick();
      tick();
      chk("cmp_we",   32'(O_REG_WRITE_ENABLE), 32'h0000);
      chk("cmp_dpen", 32'(O_DP_ENABLE), 32'h1);
      chk("cmp_op",   32'(O_OPCODE), 32'hB);
      chk("cmp_asel", 32'(O_REG_A_SELECT), 32'h2);
      I_STATUS_FLAGS = 5'b01000;
      tick();
      chk("cmp_pc", 32'(O_PC), 32'h0013);

      // BNE with Z captured: falls through
      tick();
      tick();
      chk("bne_dpen", 32'(O_DP_ENABLE), 32'h0);
      tick();
      chk("bne_pc", 32'(O_PC), 32'h0014);

      // Live flags drop, but no flag op is pending so BEQ still sees Z
      I_STATUS_FLAGS = 5'b00000;
      tick();
      tick();
      tick();
      chk("beq_pc", 32'(O_PC), 32'h0012);

      // JUC to FFFF, then BUC +1 wraps to 0000
      mem[16'h0012] = 16'h4EC0;
      I_A = 16'hFFFF;
      tick();
      tick();
      chk("juc_dpen", 32'(O_DP_ENABLE), 32'h0);
      tick();
      chk("juc_pc", 32'(O_PC), 32'hFFFF);
      tick();
      tick();
      tick();
      chk("buc_wrap_pc", 32'(O_PC), 32'h0000);

      // LOAD R4,[R5]
      I_A = 16'h0200;
      tick();
      tick();
      chk("ld_addr", 32'(O_MEM_ADDR), 32'h0200);
      chk("ld_ex_we", 32'(O_REG_WRITE_ENABLE), 32'h0000);
      tick();
      chk("ld_wb_dsel", 32'(O_REG_DATA_SELECT), 32'h1);
      chk("ld_wb_we",   32'(O_REG_WRITE_ENABLE), 32'h0010);
      chk("ld_wb_dpen", 32'(O_DP_ENABLE), 32'h1);
      chk("ld_wb_pc",   32'(O_PC), 32'h0000);
      tick();
      chk("ld_pc",   32'(O_PC), 32'h0001);
      chk("ld_dsel", 32'(O_REG_DATA_SELECT), 32'h0);

      // STOR with a one-cycle freeze in EXECUTE
      I_A = 16'h0300;
      I_B = 16'h1234;
      tick();
      tick();
      I_ENABLE = 1'b0;
      #1;
      chk("st_frozen_we", 32'(O_MEM_WE), 32'h0);
      tick();
      chk("st_hold_pc",   32'(O_PC), 32'h0001);
      chk("st_hold_addr", 32'(O_MEM_ADDR), 32'h0300);
      chk("st_hold_we",   32'(O_MEM_WE), 32'h0);
      I_ENABLE = 1'b1;
      #1;
      chk("st_we",    32'(O_MEM_WE), 32'h1);
      chk("st_addr",  32'(O_MEM_ADDR), 32'h0300);
      chk("st_wdata", 32'(O_MEM_WDATA), 32'h1234);
      tick();
      chk("st_pc",      32'(O_PC), 32'h0002);
      chk("st_we_done", 32'(O_MEM_WE), 32'h0);

      // Illegal opcode halts
      tick();
      tick();
      chk("halt_flag",    32'(O_HALTED), 32'h1);
      chk("halt_enables", 32'({O_DP_ENABLE, O_MEM_WE, O_REG_WRITE_ENABLE}), 32'h0);
      tick();
      tick();
      chk("halt_stay", 32'(O_HALTED), 32'h1);
      chk("halt_pc",   32'(O_PC), 32'h0002);

      // Reset leaves HALT
      I_RESET = 1'b1;
      tick();
      chk("unhalt_pc",     32'(O_PC), 32'h0010);
      chk("unhalt_halted", 32'(O_HALTED), 32'h0);
      I_RESET = 1'b0;

      // Reset during LOAD_WB suppresses the write
      mem[16'h0010] = 16'h4405;
      I_A = 16'h0200;
      tick();
      tick();
      chk("ld2_addr", 32'(O_MEM_ADDR), 32'h0200);
      tick();
      chk("ld2_wb_we", 32'(O_REG_WRITE_ENABLE), 32'h0010);
      I_RESET = 1'b1;
      #1;
      chk("rstwb_we",   32'(O_REG_WRITE_ENABLE), 32'h0000);
      chk("rstwb_dpen", 32'(O_DP_ENABLE), 32'h0);
      tick();
      chk("rstwb_pc",     32'(O_PC), 32'h0010);
      chk("rstwb_dsel",   32'(O_REG_DATA_SELECT), 32'h0);
      chk("rstwb_halted", 32'(O_HALTED), 32'h0);
      I_RESET = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cr16_controller.md
Name: cr16_controller

Overview:
Multi-cycle fetch/decode/execute control FSM that sits directly upstream of the CR16 datapath. It holds the PC and instruction register and drives every datapath control input: register write enables, A/B selects, immediate, ALU opcode and reg-data select. It also owns the unified instruction/data memory port and resolves conditional branches and jumps from a flag snapshot.

Parameters:
P_PC_RESET, 16'h0000, PC value loaded on reset.

Ports:
I_CLK  in  1  clock
I_RESET  in  1  reset; one clock; reset is synchronous and active-high
I_ENABLE  in  1  0 = freeze all state; O_DP_ENABLE and O_MEM_WE forced 0
I_A  in  16  datapath ALU A input (Rsrc value); used as load/store address and jump target
I_B  in  16  datapath ALU B input (Rdest value); used as store data
I_STATUS_FLAGS  in  5  datapath registered flags
I_MEM_RDATA  in  16  memory read data, valid one cycle after address
O_MEM_ADDR  out  16  memory address
O_MEM_WE  out  1  memory write strobe
O_MEM_WDATA  out  16  memory write data
O_DP_ENABLE  out  1  datapath enable
O_REG_WRITE_ENABLE  out  16  one-hot Rdest write enable
O_REG_A_SELECT  out  4  Rsrc
O_REG_B_SELECT  out  4  Rdest
O_IMMEDIATE_SELECT  out  1  1 = immediate drives ALU A
O_IMMEDIATE  out  16  extended immediate
O_OPCODE  out  4  ALU opcode
O_REG_DATA_SELECT  out  1  1 = regfile written from memory data
O_PC  out  16  current PC
O_HALTED  out  1  illegal instruction seen

Behaviour:
- IR fields: op[15:12], rdest[11:8], ext[7:4], rsrc[3:0], imm8[7:0].
- Instruction classes:
  - op 0000: RR ALU op selected by ext (AND 0001, OR 0010, XOR 0011, ADD 0101, SUB 1001, CMP 1011, MOV 1101).
  - Immediate forms (same op codes in op field, plus LUI 1111):
    - ADDI/SUBI/CMPI sign-extend imm8.
    - ANDI/ORI/XORI/MOVI zero-extend imm8.
    - LUI uses {imm8, 8'h00} with ALU MOV.
  - op 0100: ext 0000 LOAD Rdest <- mem[Rsrc]; ext 0100 STOR mem[Rsrc] <- Rdest; ext 1100 Jcond PC <- Rsrc.
  - op 1100: Bcond, PC <- PC + sext(imm8).
  - Anything else is illegal.
- States: FETCH, DECODE, EXECUTE, LOAD_WB, HALT.
- FETCH:
  - O_MEM_ADDR = PC.
  - If flag_pending: r_flags <= I_STATUS_FLAGS, clear flag_pending.
  - -> DECODE.
- DECODE: IR <= I_MEM_RDATA; -> EXECUTE, or -> HALT if illegal.
- EXECUTE, ALU ops:
  - O_DP_ENABLE = 1; write enable = one-hot(rdest), except CMP/CMPI (all 0).
  - PC <= PC+1.
  - flag_pending <= 1 for ADD/ADDI/SUB/SUBI/CMP/CMPI.
  - -> FETCH.
- EXECUTE, LOAD: O_MEM_ADDR = I_A; -> LOAD_WB.
- LOAD_WB:
  - O_DP_ENABLE = 1, O_REG_DATA_SELECT = 1, write enable = one-hot(rdest).
  - PC <= PC+1; -> FETCH.
- EXECUTE, STOR: O_MEM_ADDR = I_A, O_MEM_WDATA = I_B, O_MEM_WE = 1; PC <= PC+1.
- EXECUTE, Bcond/Jcond: O_DP_ENABLE = 0. If cond_met(rdest, r_flags), PC <= target; else PC <= PC+1.
- Latency: ALU, store and branch instructions take 3 cycles; load takes 4.
- Flags:
  - Only r_flags is used for conditions; flags clobbered by LOAD_WB or logic ops are ignored.
  - Cond codes: EQ 0000, NE 0001, CS 0010, CC 0011, HI 0100, LS 0101, GT 0110, LE 0111, FS 1000, FC 1001, LO 1010, HS 1011, LT 1100, GE 1101, UC 1110 (always), 1111 never.
- PC arithmetic is modulo 2^16: FFFF+1 -> 0000, and branch targets wrap.
- Outputs are decoded from state. In any state not listed above, all enables and strobes are 0 and O_MEM_ADDR = PC.
- HALT: O_HALTED = 1, no enables; exit only by reset.
- Reset:
  - PC = P_PC_RESET, state FETCH, IR = 0, r_flags = 0, flag_pending = 0, O_HALTED = 0.
  - All enables and strobes are 0 while I_RESET = 1; reset overrides I_ENABLE.
- Reset asserted in LOAD_WB or EXECUTE suppresses that cycle's register and memory write.
- I_ENABLE low mid-instruction: state, PC, IR and flags hold. The instruction resumes unchanged when I_ENABLE returns high.

Decomposition:
- Package cr16_pkg holds:
  - field-position localparams;
  - op/ext encodings and ALU_* opcode constants matching the ALU;
  - cond codes and FLAG_* bit indices;
  - the state enum typedef;
  - functions cond_met(cond, flags) and imm_extend(op, imm8).
- One sub-module, cr16_decoder: combinational IR -> class, ALU opcode, immediate, immediate select, writes_reg, sets_flags, illegal.

Test Plan:
- Reset with P_PC_RESET=16'h0010; release; memory[0010]=MOVI R3,#0x7F -> O_MEM_ADDR=0010 in FETCH; R3 write enable 16'h0008 with O_IMMEDIATE=007F in third cycle; PC=0011.
- ADDI R1,#-1 (imm8=FF) -> O_IMMEDIATE=FFFF; CMP R1,R2 -> O_REG_WRITE_ENABLE=0; flag_pending captured next FETCH.
- CMP equal, then BEQ disp=-2 -> PC = branch_pc-2. BNE in the same situation -> PC+1. Bcond UC at PC=FFFF, disp=+1 -> PC=0000.
- LOAD R4,[R5] with I_A=0200, mem[0200]=BEEF -> EXECUTE addr 0200; LOAD_WB O_REG_DATA_SELECT=1, enable 16'h0010; 4 cycles total.
- STOR with I_A=0300, I_B=1234 -> single-cycle O_MEM_WE=1, addr 0300, wdata 1234. I_ENABLE=0 during that EXECUTE -> O_MEM_WE=0, state held.
- Illegal op 0110 -> HALT, O_HALTED=1, no enables; I_RESET pulse during LOAD_WB -> no write, PC=P_PC_RESET, O_HALTED=0.
